// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types for the frequency-meter host bridge.
package axil_pkg;

  localparam int unsigned AXIL_DATA_WIDTH = 32;
  localparam int unsigned AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    AXIL_OKAY   = 2'b00,
    AXIL_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_WRITE = 2'd1,
    W_RESP  = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2,
    R_RESP  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/axil_mem_bridge.sv
// AXI4-Lite responder that maps host reads/writes onto the result memory's
// simple port (single-cycle strobes, 1-cycle registered read data).
// Build option FM_AXIL_WSTRB_EN: writes whose strobes do not cover every byte
// of the memory word get SLVERR and no strobe; without it s_wstrb is ignored.
module axil_mem_bridge
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned MEM_SIZE       = 30,
  parameter int unsigned AXI_ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_awaddr,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [AXIL_DATA_WIDTH-1:0] s_wdata,
  input  logic [AXIL_STRB_WIDTH-1:0] s_wstrb,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  output logic [1:0]                 s_bresp,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_araddr,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  output logic [AXIL_DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  output logic [ADDR_WIDTH-1:0]      mem_wr_addr,
  output logic [DATA_WIDTH-1:0]      mem_wr_data,
  output logic                       mem_wr_en,
  output logic [ADDR_WIDTH-1:0]      mem_rd_addr,
  output logic                       mem_rd_en,
  input  logic [DATA_WIDTH-1:0]      mem_rd_data
);

  localparam int unsigned STRB_USED = (DATA_WIDTH + 7) / 8;

  // Word index must lie inside the memory and no bits above the index may be set.
  function automatic logic addr_ok(input logic [AXI_ADDR_WIDTH-1:0] a);
    return ((a >> (ADDR_WIDTH + 2)) == '0) && (32'(a[ADDR_WIDTH+1:2]) < MEM_SIZE);
  endfunction

  // ---------------------------------------------------------------- write side
  wr_state_t             wr_state_q, wr_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  aw_latched_q, aw_latched_d;
  logic                  w_latched_q, w_latched_d;
  logic                  aw_ok_q, aw_ok_d;
  logic                  strb_ok_q, strb_ok_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                  bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d;

  logic aw_hs_c, w_hs_c, aw_seen_c, w_seen_c, strb_full_c;

  assign aw_hs_c   = s_awvalid & awready_q;
  assign w_hs_c    = s_wvalid & wready_q;
  assign aw_seen_c = aw_latched_q | aw_hs_c;
  assign w_seen_c  = w_latched_q | w_hs_c;

`ifdef FM_AXIL_WSTRB_EN
  localparam logic [AXIL_STRB_WIDTH-1:0] STRB_NEED = 4'((1 << STRB_USED) - 1);
  assign strb_full_c = (s_wstrb & STRB_NEED) == STRB_NEED;
`else
  assign strb_full_c = 1'b1;
`endif

  // Bits of the AXI payload that the narrow memory never looks at.
  logic unused_in;
  assign unused_in = ^{s_wdata, s_wstrb, s_awaddr[1:0], s_araddr[1:0]};

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) wr_state_q <= W_IDLE;
    else     wr_state_q <= wr_state_d;
  end

  // Write FSM next state: wait for both AW and W, strobe once, then respond.
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE:  if (aw_seen_c && w_seen_c) wr_state_d = W_WRITE;
      W_WRITE: wr_state_d = W_RESP;
      W_RESP:  if (bvalid_q && s_bready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write outputs: latch AW/W independently, derive readies/strobe/response from next state.
  always_comb begin
    aw_latched_d  = aw_latched_q;
    w_latched_d   = w_latched_q;
    aw_ok_d       = aw_ok_q;
    strb_ok_d     = strb_ok_q;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    bresp_d       = bresp_q;
    if (aw_hs_c) begin
      aw_latched_d  = 1'b1;
      aw_ok_d       = addr_ok(s_awaddr);
      mem_wr_addr_d = s_awaddr[ADDR_WIDTH+1:2];
    end
    if (w_hs_c) begin
      w_latched_d   = 1'b1;
      strb_ok_d     = strb_full_c;
      mem_wr_data_d = s_wdata[DATA_WIDTH-1:0];
    end
    if (wr_state_d != W_IDLE) begin
      aw_latched_d = 1'b0;
      w_latched_d  = 1'b0;
    end
    awready_d   = (wr_state_d == W_IDLE) && !aw_latched_d;
    wready_d    = (wr_state_d == W_IDLE) && !w_latched_d;
    mem_wr_en_d = (wr_state_d == W_WRITE) && aw_ok_d && strb_ok_d;
    bvalid_d    = (wr_state_d == W_RESP);
    if (wr_state_q == W_WRITE) bresp_d = (aw_ok_q && strb_ok_q) ? AXIL_OKAY : AXIL_SLVERR;
  end

  // Write output and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      aw_latched_q  <= 1'b0;
      w_latched_q   <= 1'b0;
      aw_ok_q       <= 1'b0;
      strb_ok_q     <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= AXIL_OKAY;
    end else begin
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      aw_latched_q  <= aw_latched_d;
      w_latched_q   <= w_latched_d;
      aw_ok_q       <= aw_ok_d;
      strb_ok_q     <= strb_ok_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
    end
  end

  // ----------------------------------------------------------------- read side
  rd_state_t                  rd_state_q, rd_state_d;
  logic                       arready_q, arready_d;
  logic                       rd_ok_q, rd_ok_d;
  logic                       mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0]      mem_rd_addr_q, mem_rd_addr_d;
  logic                       rvalid_q, rvalid_d;
  resp_t                      rresp_q, rresp_d;
  logic [AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic ar_hs_c;
  assign ar_hs_c = s_arvalid & arready_q;

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) rd_state_q <= R_IDLE;
    else     rd_state_q <= rd_state_d;
  end

  // Read FSM next state: issue, wait out memory latency, then respond.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs_c) rd_state_d = R_ISSUE;
      R_ISSUE: rd_state_d = R_WAIT;
      R_WAIT:  rd_state_d = R_RESP;
      R_RESP:  if (rvalid_q && s_rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read outputs: capture memory data in R_WAIT and hold it for the whole response.
  always_comb begin
    rd_ok_d       = rd_ok_q;
    mem_rd_addr_d = mem_rd_addr_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    if (ar_hs_c) begin
      rd_ok_d       = addr_ok(s_araddr);
      mem_rd_addr_d = s_araddr[ADDR_WIDTH+1:2];
    end
    arready_d   = (rd_state_d == R_IDLE);
    mem_rd_en_d = (rd_state_d == R_ISSUE) && rd_ok_d;
    rvalid_d    = (rd_state_d == R_RESP);
    if (rd_state_q == R_WAIT) begin
      rdata_d = rd_ok_q ? 32'(mem_rd_data) : '0;
      rresp_d = rd_ok_q ? AXIL_OKAY : AXIL_SLVERR;
    end
  end

  // Read output and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      arready_q     <= 1'b0;
      rd_ok_q       <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      rvalid_q      <= 1'b0;
      rresp_q       <= AXIL_OKAY;
      rdata_q       <= '0;
    end else begin
      arready_q     <= arready_d;
      rd_ok_q       <= rd_ok_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
    end
  end

  assign s_awready   = awready_q;
  assign s_wready    = wready_q;
  assign s_bvalid    = bvalid_q;
  assign s_bresp     = bresp_q;
  assign s_arready   = arready_q;
  assign s_rvalid    = rvalid_q;
  assign s_rresp     = rresp_q;
  assign s_rdata     = rdata_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;

endmodule

// File: tb/tb_axil_mem_bridge.sv
// Bench for axil_mem_bridge: directed and randomized AXI4-Lite traffic against
// a word-array model of the result memory.
module tb_axil_mem_bridge;

  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned MSZ = 30;
  localparam int unsigned AAW = 8;
  localparam int unsigned NW  = 1 << AW;

  logic           clk, rst;
  logic [AAW-1:0] s_awaddr, s_araddr;
  logic           s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0]    s_wdata, s_rdata;
  logic [3:0]     s_wstrb;
  logic [1:0]     s_bresp, s_rresp;
  logic           s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0]  mem_wr_addr, mem_rd_addr;
  logic [DW-1:0]  mem_wr_data, mem_rd_data;
  logic           mem_wr_en, mem_rd_en;

  axil_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MSZ), .AXI_ADDR_WIDTH(AAW)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result memory stand-in: registered read, read-before-write.
  logic [DW-1:0] mem [NW];
  initial for (int i = 0; i < int'(NW); i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  // Strobe counters seen by the memory.
  int wr_cnt = 0;
  int rd_cnt = 0;
  always @(posedge clk) begin
    if (mem_wr_en) wr_cnt++;
    if (mem_rd_en) rd_cnt++;
  end

  // Reference model: plain word array indexed by byte address / 4.
  logic [DW-1:0] model [NW];
  int vectors = 0;
  int miscompares = 0;

  function automatic bit exp_ok(input logic [AAW-1:0] a);
    int unsigned w;
    w = int'(a) / 4;
    return (w < MSZ) && (w < NW);
  endfunction

  function automatic bit exp_strb_ok(input logic [3:0] s);
    bit en;
    logic [3:0] need;
`ifdef FM_AXIL_WSTRB_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    need = 4'((1 << ((DW + 7) / 8)) - 1);
    return !en || ((s & need) == need);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axil_write(input logic [AAW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly);
    bit aw_done, w_done, aw_fire, w_fire, ok;
    int t, wc0;
    aw_done = 0; w_done = 0; t = 0;
    ok  = exp_ok(addr) && exp_strb_ok(strb);
    wc0 = wr_cnt;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb; s_bready = 1'b0;
    while (!(aw_done && w_done) && t < 40) begin
      s_awvalid = !aw_done && (t >= aw_dly);
      s_wvalid  = !w_done && (t >= w_dly);
      aw_fire = s_awvalid && s_awready;
      w_fire  = s_wvalid && s_wready;
      @(negedge clk); t++;
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("wr_handshake", 32'(aw_done && w_done), 32'd1);
    check("wr_strobe", 32'(mem_wr_en), 32'(ok));
    check("wr_bvalid_early", 32'(s_bvalid), 32'd0);
    if (ok) begin
      check("wr_index", 32'(mem_wr_addr), 32'(4'(addr >> 2)));
      check("wr_data", 32'(mem_wr_data), 32'(data[DW-1:0]));
    end
    @(negedge clk);
    check("wr_bvalid", 32'(s_bvalid), 32'd1);
    check("wr_bresp", 32'(s_bresp), ok ? 32'd0 : 32'd2);
    check("wr_strobe_count", 32'(wr_cnt - wc0), 32'(ok));
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check("wr_bvalid_hold", 32'(s_bvalid), 32'd1);
      check("wr_awready_blocked", 32'(s_awready), 32'd0);
    end
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    check("wr_bvalid_drop", 32'(s_bvalid), 32'd0);
    check("wr_awready_back", 32'(s_awready), 32'd1);
    if (ok) model[4'(addr >> 2)] = data[DW-1:0];
  endtask

  task automatic axil_read(input logic [AAW-1:0] addr, input int ar_dly, input int r_dly);
    bit done, fire, ok;
    int t, rc0;
    logic [31:0] exp_d;
    done = 0; t = 0;
    ok    = exp_ok(addr);
    exp_d = ok ? 32'(model[4'(addr >> 2)]) : 32'd0;
    rc0   = rd_cnt;
    s_araddr = addr; s_rready = 1'b0;
    while (!done && t < 40) begin
      s_arvalid = (t >= ar_dly);
      fire = s_arvalid && s_arready;
      @(negedge clk); t++;
      done = fire;
    end
    s_arvalid = 1'b0;
    check("rd_handshake", 32'(done), 32'd1);
    check("rd_strobe", 32'(mem_rd_en), 32'(ok));
    check("rd_arready_low", 32'(s_arready), 32'd0);
    if (ok) check("rd_index", 32'(mem_rd_addr), 32'(4'(addr >> 2)));
    @(negedge clk);
    check("rd_rvalid_early", 32'(s_rvalid), 32'd0);
    @(negedge clk);
    check("rd_rvalid", 32'(s_rvalid), 32'd1);
    check("rd_rdata", s_rdata, exp_d);
    check("rd_rresp", 32'(s_rresp), ok ? 32'd0 : 32'd2);
    check("rd_strobe_count", 32'(rd_cnt - rc0), 32'(ok));
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      check("rd_rvalid_hold", 32'(s_rvalid), 32'd1);
      check("rd_rdata_hold", s_rdata, exp_d);
      check("rd_arready_blocked", 32'(s_arready), 32'd0);
    end
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
    check("rd_rvalid_drop", 32'(s_rvalid), 32'd0);
    check("rd_arready_back", 32'(s_arready), 32'd1);
  endtask

  initial begin
    int hs, c0;
    logic [AAW-1:0] ra;
    for (int i = 0; i < int'(NW); i++) model[i] = '0;
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
    s_araddr = '0; s_arvalid = 0; s_rready = 0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_awready", 32'(s_awready), 32'd0);
    check("rst_wready", 32'(s_wready), 32'd0);
    check("rst_arready", 32'(s_arready), 32'd0);
    check("rst_valids", 32'({s_bvalid, s_rvalid}), 32'd0);
    check("rst_resps", 32'({s_bresp, s_rresp}), 32'd0);
    check("rst_rdata", s_rdata, 32'd0);
    check("rst_strobes", 32'({mem_wr_en, mem_rd_en}), 32'd0);
    check("rst_mem_bus", 32'({mem_wr_addr, mem_wr_data, mem_rd_addr}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_readies", 32'({s_awready, s_wready, s_arready}), 32'd7);

    // Directed transactions.
    axil_write(8'h08, 32'h0000_BEEF, 4'hF, 0, 2, 0);
    axil_write(8'h78, 32'h0000_1234, 4'hF, 0, 0, 1);
    axil_read(8'h08, 0, 0);
    axil_read(8'hFC, 1, 0);
    axil_read(8'h08, 0, 5);
    axil_write(8'h3C, 32'hFFFF_CAFE, 4'hF, 3, 0, 0);
    axil_read(8'h3F, 0, 1);
    axil_read(8'h40, 0, 0);
    axil_write(8'h0C, 32'h0000_5A5A, 4'b0001, 0, 0, 0);
    axil_read(8'h0C, 0, 0);

    // Same-index read and write strobed in one cycle: read sees the old word.
    axil_write(8'h10, 32'h0000_1111, 4'hF, 0, 0, 0);
    s_awaddr = 8'h10; s_wdata = 32'h0000_2222; s_wstrb = 4'hF; s_araddr = 8'h10;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    check("ovl_strobes", 32'({mem_wr_en, mem_rd_en}), 32'd3);
    @(negedge clk);
    check("ovl_bvalid", 32'(s_bvalid), 32'd1);
    @(negedge clk);
    check("ovl_rvalid", 32'(s_rvalid), 32'd1);
    check("ovl_old_data", s_rdata, 32'h0000_1111);
    s_bready = 1; s_rready = 1;
    @(negedge clk);
    s_bready = 0; s_rready = 0;
    check("ovl_valids_drop", 32'({s_bvalid, s_rvalid}), 32'd0);
    model[4] = 16'h2222;
    axil_read(8'h10, 0, 0);

    // Back-to-back writes: one per 3 cycles.
    s_awaddr = 8'h18; s_wdata = 32'h0000_A5A5; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1; s_bready = 1; hs = 0; c0 = wr_cnt;
    for (int i = 0; i < 12; i++) begin
      if (s_awready && s_wready) hs++;
      @(negedge clk);
    end
    s_awvalid = 0; s_wvalid = 0; s_bready = 0;
    check("b2b_wr_handshakes", 32'(hs), 32'd4);
    check("b2b_wr_strobes", 32'(wr_cnt - c0), 32'd4);
    check("b2b_wr_idle", 32'({s_bvalid, s_awready}), 32'd1);
    model[6] = 16'hA5A5;

    // Back-to-back reads: one per 4 cycles.
    s_araddr = 8'h18; s_arvalid = 1; s_rready = 1; hs = 0; c0 = rd_cnt;
    for (int i = 0; i < 12; i++) begin
      if (s_arready) hs++;
      @(negedge clk);
    end
    s_arvalid = 0; s_rready = 0;
    check("b2b_rd_handshakes", 32'(hs), 32'd3);
    check("b2b_rd_strobes", 32'(rd_cnt - c0), 32'd3);
    check("b2b_rd_data", s_rdata, 32'h0000_A5A5);
    check("b2b_rd_idle", 32'({s_rvalid, s_arready}), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      ra = AAW'($urandom_range(0, 95));
      if ($urandom_range(0, 1) == 1)
        axil_write(ra, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axil_read(ra, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset coinciding with the AW/W handshake: nothing is written.
    c0 = wr_cnt;
    s_awaddr = 8'h20; s_wdata = 32'h0000_9999; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1; rst = 1;
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    check("rstw_no_strobe", 32'(mem_wr_en), 32'd0);
    check("rstw_readies", 32'({s_awready, s_wready, s_arready}), 32'd0);
    rst = 0;
    repeat (3) @(negedge clk);
    check("rstw_no_resp", 32'(s_bvalid), 32'd0);
    check("rstw_strobe_count", 32'(wr_cnt - c0), 32'd0);

    // Reset while a read waits on memory: response is dropped.
    s_araddr = 8'h08; s_arvalid = 1;
    @(negedge clk);
    s_arvalid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rstr_rvalid", 32'(s_rvalid), 32'd0);
    @(negedge clk);
    check("rstr_arready", 32'(s_arready), 32'd1);
    check("rstr_rvalid_after", 32'(s_rvalid), 32'd0);

    // Reset while bvalid is up: bvalid falls on the next edge.
    s_awaddr = 8'h14; s_wdata = 32'h0000_7777; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1;
    @(negedge clk);
    s_awvalid = 0; s_wvalid = 0;
    @(negedge clk);
    check("rstb_bvalid_up", 32'(s_bvalid), 32'd1);
    model[5] = 16'h7777;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rstb_bvalid_drop", 32'(s_bvalid), 32'd0);
    @(negedge clk);

    // Read back every word and compare with the model.
    for (int i = 0; i < int'(NW); i++) axil_read(AAW'(i * 4), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
